// File: rtl/sdram_init_ref.sv
// SDRAM power-up initialisation and periodic auto-refresh controller.
// Drives PRECHARGE ALL, INIT_REF_NUM x AUTO REFRESH and LOAD MODE after a
// power-up wait, then schedules refreshes via a Ref_req/Ref_en handshake.
// Ports:
//   Clk, Rst_n  : clock, asynchronous active-low reset
//   Command     : {CS_N,RAS_N,CAS_N,WE_N}, NOP when idle
//   Saddr, Sba  : SDRAM address / bank address (Sba always 0)
//   Init_done   : high once init completes, until reset
//   Ref_req     : refresh request to arbiter; Ref_en is the grant
//   Ref_done    : one-cycle pulse at the end of a refresh sequence
//   Ref_late    : one-cycle pulse when an interval expires with Ref_req pending
module sdram_init_ref #(
    parameter int unsigned ASIZE        = 13,
    parameter int unsigned BASIZE       = 2,
    parameter int unsigned INIT_WAIT    = 20000,
    parameter int unsigned TRP          = 2,
    parameter int unsigned TRC          = 7,
    parameter int unsigned TMRD         = 2,
    parameter int unsigned INIT_REF_NUM = 8,
    parameter int unsigned REF_PERIOD   = 780,
    parameter logic [2:0]  CAS_LAT      = 3'd3,
    parameter logic [2:0]  BURST_LEN    = 3'b011
) (
    input  logic              Clk,
    input  logic              Rst_n,
    output logic [3:0]        Command,
    output logic [ASIZE-1:0]  Saddr,
    output logic [BASIZE-1:0] Sba,
    output logic              Init_done,
    output logic              Ref_req,
    input  logic              Ref_en,
    output logic              Ref_done,
    output logic              Ref_late
);

    localparam int unsigned MX1  = (INIT_WAIT > REF_PERIOD) ? INIT_WAIT : REF_PERIOD;
    localparam int unsigned MX2  = (TRC > TRP) ? TRC : TRP;
    localparam int unsigned MX3  = (TMRD > INIT_REF_NUM) ? TMRD : INIT_REF_NUM;
    localparam int unsigned MX4  = (MX2 > MX3) ? MX2 : MX3;
    localparam int unsigned MAXP = (MX1 > MX4) ? MX1 : MX4;
    localparam int unsigned CW   = $clog2(MAXP + 1);
    localparam int unsigned TW   = $clog2(REF_PERIOD);
    localparam int unsigned RW   = $clog2(INIT_REF_NUM + 1);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    localparam logic [ASIZE-1:0] ADDR_A10  = ASIZE'(11'h400);
    localparam logic [ASIZE-1:0] ADDR_MODE =
        ASIZE'({1'b0, 2'b00, CAS_LAT, 1'b0, BURST_LEN});

    localparam logic [CW-1:0] C_WAIT = CW'(INIT_WAIT);
    localparam logic [CW-1:0] C_TRP  = CW'(TRP - 1);
    localparam logic [CW-1:0] C_TRC  = CW'(TRC - 1);
    localparam logic [CW-1:0] C_TMRD = CW'(TMRD - 1);
    localparam logic [TW-1:0] T_LAST = TW'(REF_PERIOD - 1);
    localparam logic [RW-1:0] R_NUM  = RW'(INIT_REF_NUM);

    typedef enum logic [3:0] {
        S_INIT_WAIT,
        S_INIT_PRE,
        S_INIT_TRP,
        S_INIT_AREF,
        S_INIT_TRC,
        S_INIT_MRS,
        S_INIT_TMRD,
        S_IDLE,
        S_REF_PRE,
        S_REF_TRP,
        S_REF_AREF,
        S_REF_TRC
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [RW-1:0]    arefs_q;
    logic [TW-1:0]    timer_q;
    logic [3:0]       cmd_q;
    logic [ASIZE-1:0] saddr_q;
    logic             init_done_q;
    logic             ref_req_q;
    logic             ref_done_q;
    logic             ref_late_q;

    // Command states are entered on the edge that issues the command; cnt_q
    // then counts edges since that command, so the next command fires when
    // cnt_q reaches gap-1 (a gap of 1 skips the wait state entirely).
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_INIT_WAIT;
            cnt_q       <= '0;
            arefs_q     <= '0;
            timer_q     <= '0;
            cmd_q       <= CMD_NOP;
            saddr_q     <= '0;
            init_done_q <= 1'b0;
            ref_req_q   <= 1'b0;
            ref_done_q  <= 1'b0;
            ref_late_q  <= 1'b0;
        end else begin
            cmd_q      <= CMD_NOP;
            saddr_q    <= '0;
            ref_done_q <= 1'b0;
            ref_late_q <= 1'b0;
            cnt_q      <= cnt_q + CW'(1);

            // Free-running interval timer; a pending request is never doubled.
            if (init_done_q) begin
                if (timer_q == T_LAST) begin
                    timer_q <= '0;
                    if (ref_req_q) ref_late_q <= 1'b1;
                    else           ref_req_q  <= 1'b1;
                end else begin
                    timer_q <= timer_q + TW'(1);
                end
            end

            case (state_q)
                S_INIT_WAIT: begin
                    if (cnt_q == C_WAIT) begin
                        state_q <= S_INIT_PRE;
                        cmd_q   <= CMD_PRE;
                        saddr_q <= ADDR_A10;
                        cnt_q   <= '0;
                    end
                end
                S_INIT_PRE, S_INIT_TRP: begin
                    if (cnt_q == C_TRP) begin
                        state_q <= S_INIT_AREF;
                        cmd_q   <= CMD_AREF;
                        arefs_q <= arefs_q + RW'(1);
                        cnt_q   <= '0;
                    end else begin
                        state_q <= S_INIT_TRP;
                    end
                end
                S_INIT_AREF, S_INIT_TRC: begin
                    if (cnt_q == C_TRC) begin
                        cnt_q <= '0;
                        if (arefs_q == R_NUM) begin
                            state_q <= S_INIT_MRS;
                            cmd_q   <= CMD_LMR;
                            saddr_q <= ADDR_MODE;
                        end else begin
                            state_q <= S_INIT_AREF;
                            cmd_q   <= CMD_AREF;
                            arefs_q <= arefs_q + RW'(1);
                        end
                    end else begin
                        state_q <= S_INIT_TRC;
                    end
                end
                S_INIT_MRS, S_INIT_TMRD: begin
                    if (cnt_q == C_TMRD) begin
                        state_q     <= S_IDLE;
                        init_done_q <= 1'b1;
                        timer_q     <= '0;
                    end else begin
                        state_q <= S_INIT_TMRD;
                    end
                end
                S_IDLE: begin
                    if (Ref_en && ref_req_q) begin
                        state_q   <= S_REF_PRE;
                        cmd_q     <= CMD_PRE;
                        saddr_q   <= ADDR_A10;
                        ref_req_q <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                S_REF_PRE, S_REF_TRP: begin
                    if (cnt_q == C_TRP) begin
                        state_q <= S_REF_AREF;
                        cmd_q   <= CMD_AREF;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= S_REF_TRP;
                    end
                end
                S_REF_AREF, S_REF_TRC: begin
                    if (cnt_q == C_TRC) begin
                        state_q    <= S_IDLE;
                        ref_done_q <= 1'b1;
                    end else begin
                        state_q <= S_REF_TRC;
                    end
                end
                default: begin
                    state_q <= S_INIT_WAIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign Command   = cmd_q;
    assign Saddr     = saddr_q;
    assign Sba       = '0;
    assign Init_done = init_done_q;
    assign Ref_req   = ref_req_q;
    assign Ref_done  = ref_done_q;
    assign Ref_late  = ref_late_q;

endmodule

// File: tb/tb_sdram_init_ref.sv
// Testbench for sdram_init_ref: cycle-arithmetic reference model,
// directed timeline pins and randomized grant/reset stimulus.
module tb_sdram_init_ref;

    localparam int IW   = 10;
    localparam int TRP  = 2;
    localparam int TRC  = 7;
    localparam int TMRD = 2;
    localparam int NUM  = 2;
    localparam int RP   = 50;
    localparam int M    = IW + TRP + NUM * TRC;
    localparam int D    = M + TMRD;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] LMR  = 4'b0000;

    localparam logic [12:0] A10   = 13'h400;
    localparam logic [12:0] MODE1 = 13'(3 * 16 + 3);
    localparam logic [12:0] MODE2 = 13'(2 * 16 + 7);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ref_en = 1'b0;
    logic [3:0]  cmd, cmd2;
    logic [12:0] sa, sa2;
    logic [1:0]  sba, sba2;
    logic        idone, idone2, rreq, rreq2;
    logic        rdone, rdone2, rlate, rlate2;

    sdram_init_ref #(
        .ASIZE(13), .BASIZE(2), .INIT_WAIT(IW), .TRP(TRP), .TRC(TRC),
        .TMRD(TMRD), .INIT_REF_NUM(NUM), .REF_PERIOD(RP),
        .CAS_LAT(3'd3), .BURST_LEN(3'b011)
    ) dut (
        .Clk(clk), .Rst_n(rst_n), .Command(cmd), .Saddr(sa), .Sba(sba),
        .Init_done(idone), .Ref_req(rreq), .Ref_en(ref_en),
        .Ref_done(rdone), .Ref_late(rlate)
    );

    sdram_init_ref #(
        .ASIZE(13), .BASIZE(2), .INIT_WAIT(IW), .TRP(TRP), .TRC(TRC),
        .TMRD(TMRD), .INIT_REF_NUM(NUM), .REF_PERIOD(RP),
        .CAS_LAT(3'd2), .BURST_LEN(3'b111)
    ) dut2 (
        .Clk(clk), .Rst_n(rst_n), .Command(cmd2), .Saddr(sa2), .Sba(sba2),
        .Init_done(idone2), .Ref_req(rreq2), .Ref_en(ref_en),
        .Ref_done(rdone2), .Ref_late(rlate2)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state
    int          cyc = -1;
    int          seq_pre = -1000;
    bit          m_req = 1'b0;
    bit          old_req, grant, expire;
    logic [3:0]  e_cmd = NOP;
    logic [12:0] e_sa = '0;
    logic [12:0] e_sa2 = '0;
    logic        e_idone = 1'b0;
    logic        e_done = 1'b0;
    logic        e_late = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: cycle %0d got %0h expected %0h",
                      name, cyc, act, exp);
    endtask

    // Outputs at cycle n are what the DUT holds after the n-th rising edge
    // since reset release; everything below is timeline arithmetic.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            cyc = -1;
            seq_pre = -1000;
            m_req = 1'b0;
            e_cmd = NOP;
            e_sa = '0;
            e_sa2 = '0;
            e_idone = 1'b0;
            e_done = 1'b0;
            e_late = 1'b0;
        end else begin
            cyc++;
            e_cmd = NOP;
            e_sa = '0;
            e_sa2 = '0;
            e_done = 1'b0;
            e_late = 1'b0;
            if (cyc == IW) begin
                e_cmd = PRE; e_sa = A10; e_sa2 = A10;
            end
            for (int k = 0; k < NUM; k++)
                if (cyc == IW + TRP + k * TRC) e_cmd = AREF;
            if (cyc == M) begin
                e_cmd = LMR; e_sa = MODE1; e_sa2 = MODE2;
            end
            e_idone = (cyc >= D);
            if (cyc > D) begin
                old_req = m_req;
                grant = old_req && ref_en && (cyc > seq_pre + TRP + TRC);
                expire = ((cyc - D) % RP) == 0;
                if (grant) seq_pre = cyc;
                if (grant) m_req = 1'b0;
                if (expire && !old_req) m_req = 1'b1;
                e_late = expire && old_req;
                if (cyc == seq_pre) begin
                    e_cmd = PRE; e_sa = A10; e_sa2 = A10;
                end
                if (cyc == seq_pre + TRP) e_cmd = AREF;
                if (cyc == seq_pre + TRP + TRC) e_done = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("command", cmd, e_cmd);
        chk("saddr", sa, e_sa);
        chk("sba", sba, 0);
        chk("init_done", idone, e_idone);
        chk("ref_req", rreq, m_req);
        chk("ref_done", rdone, e_done);
        chk("ref_late", rlate, e_late);
        chk("command2", cmd2, e_cmd);
        chk("saddr2", sa2, e_sa2);
    end

    task automatic at_cycle(input int t);
        int guard;
        guard = 0;
        @(negedge clk);
        while (cyc != t && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != t) begin
            n_chk++;
            $display("FAIL wait_cycle: cycle %0d got %0d expected %0d",
                     cyc, cyc, t);
        end
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_command", cmd, NOP);
        chk("rst_saddr", sa, 0);
        chk("rst_init_done", idone, 0);
        chk("rst_ref_req", rreq, 0);
        chk("rst_ref_done", rdone, 0);
        chk("rst_ref_late", rlate, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int p;
        rst_n = 1'b0;
        ref_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("lit_reset_cmd", cmd, NOP);
        chk("lit_reset_idone", idone, 0);

        // Grant tied high from the start: ignored during init, then
        // every request is taken at once.
        ref_en = 1'b1;
        rst_n = 1'b1;
        at_cycle(10);
        chk("lit_pre_cmd", cmd, PRE);
        chk("lit_pre_a10", sa, 13'h400);
        at_cycle(12);
        chk("lit_aref0", cmd, AREF);
        at_cycle(19);
        chk("lit_aref1", cmd, AREF);
        at_cycle(26);
        chk("lit_lmr_cmd", cmd, LMR);
        chk("lit_lmr_addr", sa, 13'h0033);
        chk("lit_lmr_addr2", sa2, 13'h0027);
        at_cycle(27);
        chk("lit_idone_27", idone, 0);
        at_cycle(28);
        chk("lit_idone_28", idone, 1);
        at_cycle(77);
        chk("lit_req_77", rreq, 0);
        at_cycle(78);
        chk("lit_req_78", rreq, 1);
        at_cycle(79);
        chk("lit_ref_pre", cmd, PRE);
        chk("lit_req_79", rreq, 0);
        at_cycle(81);
        chk("lit_ref_aref", cmd, AREF);
        at_cycle(88);
        chk("lit_ref_done", rdone, 1);
        at_cycle(128);
        chk("lit_req_128", rreq, 1);

        // Delayed grant
        pulse_reset();
        ref_en = 1'b0;
        at_cycle(128);
        chk("lit_late_128", rlate, 1);
        at_cycle(178);
        chk("lit_late_178", rlate, 1);
        at_cycle(200);
        chk("lit_req_200", rreq, 1);
        ref_en = 1'b1;
        at_cycle(201);
        ref_en = 1'b0;
        chk("lit_dg_pre", cmd, PRE);
        chk("lit_dg_req", rreq, 0);
        at_cycle(203);
        chk("lit_dg_aref", cmd, AREF);
        at_cycle(210);
        chk("lit_dg_done", rdone, 1);

        // Reset during init and during a refresh sequence
        pulse_reset();
        ref_en = 1'b1;
        at_cycle(15);
        pulse_reset();
        at_cycle(10);
        chk("lit_rinit_pre", cmd, PRE);
        at_cycle(80);
        pulse_reset();
        at_cycle(26);
        chk("lit_rref_lmr", sa, 13'h0033);
        at_cycle(28);
        chk("lit_rref_idone", idone, 1);

        // Randomized grants with occasional resets
        for (int blk = 0; blk < 20; blk++) begin
            p = $urandom_range(0, 10);
            repeat (200) begin
                @(negedge clk);
                ref_en = ($urandom_range(0, 9) < p);
                if ($urandom_range(0, 999) == 0) pulse_reset();
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
